// File: rtl/traffic_light_ctrl_param.sv
// Highway/local-road traffic light controller with actuated local-road green.
// Optional night flashing mode is built only when FLASH_MODE_EN is defined.
module traffic_light_ctrl_param #(
    parameter int HW_MIN_GREEN = 70,
    parameter int YELLOW       = 25,
    parameter int ALL_RED      = 1,
    parameter int LR_MIN_GREEN = 10,
    parameter int LR_MAX_GREEN = 70,
    parameter int FLASH_HALF   = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lr_has_car,
    input  logic       flash_en,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic [2:0] state_o
);

    // state   | meaning
    // HW_GO   | highway green, local red; waits for min green and a local car
    // HW_WAIT | highway yellow
    // TO_LR   | all-red clearance before local green
    // LR_GO   | local green; gap-out after min green or hard stop at max
    // LR_WAIT | local yellow
    // TO_HW   | all-red clearance before highway green
    // FLASH   | night mode: highway flashes yellow, local flashes red
    typedef enum logic [2:0] {
        HW_GO   = 3'b000,
        HW_WAIT = 3'b001,
        TO_LR   = 3'b010,
        LR_GO   = 3'b011,
        LR_WAIT = 3'b100,
`ifdef FLASH_MODE_EN
        TO_HW   = 3'b101,
        FLASH   = 3'b110
`else
        TO_HW   = 3'b101
`endif
    } state_t;

    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;

    localparam logic [CNT_W-1:0] HW_MIN_M1     = CNT_W'(HW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] ALL_RED_M1    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LR_MIN_M1     = CNT_W'(LR_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LR_MAX_M1     = CNT_W'(LR_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] FLASH_HALF_M1 = CNT_W'(FLASH_HALF - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;

`ifdef FLASH_MODE_EN
    logic phase;
    logic flash_wrap;

    assign flash_wrap = (state == FLASH) && (timer == FLASH_HALF_M1);
`else
    logic [CNT_W:0] unused_cfg;

    assign unused_cfg = {flash_en, FLASH_HALF_M1};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HW_GO;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
`ifdef FLASH_MODE_EN
            end else if (flash_wrap) begin
                timer <= '0;
`endif
            end else if (timer != {CNT_W{1'b1}}) begin
                timer <= timer + 1'b1;
            end
        end
    end

`ifdef FLASH_MODE_EN
    // Phase restarts lit on every entry into FLASH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (state_next == FLASH && state != FLASH) begin
            phase <= 1'b0;
        end else if (flash_wrap) begin
            phase <= ~phase;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            HW_GO:   if (timer >= HW_MIN_M1 && lr_has_car) state_next = HW_WAIT;
            HW_WAIT: if (timer == YELLOW_M1) state_next = TO_LR;
            TO_LR:   if (timer == ALL_RED_M1) state_next = LR_GO;
            LR_GO:   if (timer == LR_MAX_M1 || (timer >= LR_MIN_M1 && !lr_has_car))
                         state_next = LR_WAIT;
            LR_WAIT: if (timer == YELLOW_M1) state_next = TO_HW;
            TO_HW:   if (timer == ALL_RED_M1) state_next = HW_GO;
`ifdef FLASH_MODE_EN
            FLASH:   state_next = TO_HW;
`endif
            default: state_next = HW_GO;
        endcase
`ifdef FLASH_MODE_EN
        // Flash request overrides every normal transition.
        if (flash_en) state_next = FLASH;
`endif
    end

    always_comb begin
        hw_light = LAMP_R;
        lr_light = LAMP_R;
        case (state)
            HW_GO:   hw_light = LAMP_G;
            HW_WAIT: hw_light = LAMP_Y;
            LR_GO:   lr_light = LAMP_G;
            LR_WAIT: lr_light = LAMP_Y;
`ifdef FLASH_MODE_EN
            FLASH: begin
                hw_light = phase ? 3'b000 : LAMP_Y;
                lr_light = phase ? 3'b000 : LAMP_R;
            end
`endif
            default: begin
                hw_light = LAMP_R;
                lr_light = LAMP_R;
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: table-driven phase model checked every cycle,
// plus hand-computed literal checkpoints. Honours FLASH_MODE_EN like the design.
module tb_traffic_light_ctrl_param;

    localparam int HW_MIN  = 70;
    localparam int YEL     = 25;
    localparam int AR      = 1;
    localparam int LR_MIN  = 10;
    localparam int LR_MAX  = 70;
    localparam int FHALF   = 8;
`ifdef FLASH_MODE_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lr_has_car = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] hw_light, lr_light, state_o;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;

    traffic_light_ctrl_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lr_has_car(lr_has_car),
        .flash_en  (flash_en),
        .hw_light  (hw_light),
        .lr_light  (lr_light),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Phase table: the six normal phases in cyclic order.
    logic [2:0] tab_hw [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [2:0] tab_lr [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
    int         tab_dur[6] = '{HW_MIN, YEL, AR, LR_MAX, YEL, AR};

    int m_ph = 0;
    int m_el = 0;
    bit m_fl = 1'b0;
    bit m_lit = 1'b1;

    always @(posedge clk or negedge rst_n) begin : model
        int  nph, nel;
        bit  nfl, nlit, done;
        if (!rst_n) begin
            m_ph  <= 0;
            m_el  <= 0;
            m_fl  <= 1'b0;
            m_lit <= 1'b1;
        end else begin
            nph  = m_ph;
            nel  = m_el + 1;
            nfl  = m_fl;
            nlit = m_lit;
            done = 1'b0;
            if (FLASH_ON && flash_en) begin
                if (!m_fl) begin
                    nfl = 1'b1; nel = 0; nlit = 1'b1;
                end else if (m_el == FHALF - 1) begin
                    nel = 0; nlit = !m_lit;
                end
            end else if (m_fl) begin
                nfl = 1'b0; nph = 5; nel = 0;
            end else begin
                if (m_ph == 0)      done = (m_el >= HW_MIN - 1) && lr_has_car;
                else if (m_ph == 3) done = (m_el == LR_MAX - 1) || ((m_el >= LR_MIN - 1) && !lr_has_car);
                else                done = (m_el == tab_dur[m_ph] - 1);
                if (done) begin
                    nph = (m_ph + 1) % 6;
                    nel = 0;
                end
            end
            m_ph  <= nph;
            m_el  <= nel;
            m_fl  <= nfl;
            m_lit <= nlit;
        end
    end

    task automatic compare(input string name, input logic [2:0] ehw, input logic [2:0] elr,
                           input logic [2:0] est);
        vectors++;
        if (hw_light !== ehw || lr_light !== elr || state_o !== est) begin
            miscompares++;
            $display("FAIL %s: got hw=%b lr=%b st=%b, required hw=%b lr=%b st=%b (t=%0t)",
                     name, hw_light, lr_light, state_o, ehw, elr, est, $time);
        end
    endtask

    task automatic check_model();
        logic [2:0] ehw, elr, est;
        if (m_fl) begin
            ehw = m_lit ? 3'b010 : 3'b000;
            elr = m_lit ? 3'b001 : 3'b000;
            est = 3'b110;
        end else begin
            ehw = tab_hw[m_ph];
            elr = tab_lr[m_ph];
            est = 3'(m_ph);
        end
        compare("model", ehw, elr, est);
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    // Returns at the falling edge right after rising edge k (cycle 0 = first after release).
    task automatic at_edge(input int k);
        int guard = 0;
        while (edge_cnt != k + 1) begin
            tick();
            guard++;
            if (guard > 3000) begin
                miscompares++;
                $display("FAIL at_edge_timeout: edge_cnt=%0d, required %0d", edge_cnt, k + 1);
                return;
            end
        end
    endtask

    task automatic do_reset(input logic car);
        @(negedge clk);
        rst_n = 1'b0;
        flash_en = 1'b0;
        lr_has_car = car;
        tick();
        compare("in_reset", 3'b100, 3'b001, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
    endtask

    initial begin
        #1;
        compare("por", 3'b100, 3'b001, 3'b000);

        // 1: car held -> full cycle with max local green
        do_reset(1'b1);
        at_edge(68);  compare("t1_hw_green_end", 3'b100, 3'b001, 3'b000);
        at_edge(69);  compare("t1_hw_yellow",    3'b010, 3'b001, 3'b001);
        at_edge(93);  compare("t1_hw_yel_end",   3'b010, 3'b001, 3'b001);
        at_edge(94);  compare("t1_to_lr",        3'b001, 3'b001, 3'b010);
        at_edge(95);  compare("t1_lr_green",     3'b001, 3'b100, 3'b011);
        at_edge(164); compare("t1_lr_max_end",   3'b001, 3'b100, 3'b011);
        at_edge(165); compare("t1_lr_yellow",    3'b001, 3'b010, 3'b100);
        at_edge(189); compare("t1_lr_yel_end",   3'b001, 3'b010, 3'b100);
        at_edge(190); compare("t1_to_hw",        3'b001, 3'b001, 3'b101);
        at_edge(191); compare("t1_hw_again",     3'b100, 3'b001, 3'b000);

        // 2: no car for 500 cycles -> highway green throughout, timer saturates silently
        do_reset(1'b0);
        at_edge(499); compare("t2_hold", 3'b100, 3'b001, 3'b000);

        // 3: early pulse ignored, later steady car honoured on edge 100
        do_reset(1'b0);
        at_edge(29);  lr_has_car = 1'b1;
        at_edge(30);  lr_has_car = 1'b0;
        compare("t3_pulse_ignored", 3'b100, 3'b001, 3'b000);
        at_edge(99);  compare("t3_pre", 3'b100, 3'b001, 3'b000);
        lr_has_car = 1'b1;
        at_edge(100); compare("t3_hw_wait", 3'b010, 3'b001, 3'b001);

        // 4: gap-out at min local green, car dropped at local green cycle 3
        do_reset(1'b1);
        at_edge(98);  lr_has_car = 1'b0;
        at_edge(104); compare("t4_lr_green_last", 3'b001, 3'b100, 3'b011);
        at_edge(105); compare("t4_gap_out",       3'b001, 3'b010, 3'b100);
        at_edge(115); compare("t4_lr_yellow",     3'b001, 3'b010, 3'b100);

        // 5: asynchronous reset mid local yellow
        #2 rst_n = 1'b0;
        #1 compare("t5_async_reset", 3'b100, 3'b001, 3'b000);

        // 6: flash request during local green
        do_reset(1'b1);
        at_edge(100); flash_en = 1'b1;
`ifdef FLASH_MODE_EN
        at_edge(101); compare("t6_flash_on",   3'b010, 3'b001, 3'b110);
        at_edge(108); compare("t6_lit_end",    3'b010, 3'b001, 3'b110);
        at_edge(109); compare("t6_dark",       3'b000, 3'b000, 3'b110);
        at_edge(116); compare("t6_dark_end",   3'b000, 3'b000, 3'b110);
        at_edge(117); compare("t6_lit_again",  3'b010, 3'b001, 3'b110);
        at_edge(120); flash_en = 1'b0;
        at_edge(121); compare("t6_clear",      3'b001, 3'b001, 3'b101);
        at_edge(122); compare("t6_hw_go",      3'b100, 3'b001, 3'b000);
`else
        at_edge(101); compare("t6_nf_lr_go",   3'b001, 3'b100, 3'b011);
        at_edge(120); flash_en = 1'b0;
        at_edge(121); compare("t6_nf_lr_go2",  3'b001, 3'b100, 3'b011);
        at_edge(165); compare("t6_nf_lr_yel",  3'b001, 3'b010, 3'b100);
`endif
        at_edge(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
